// File: rtl/id_stage.sv
// ============================================================================
// Module   : id_stage
// Function : Instruction decode, 32x32 register file and ID/EX pipeline
//            register. Optional macro ID_WB_BYPASS_EN enables write-first
//            forwarding of same-cycle write-back data to the read ports.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        flush,
    input  logic [31:0] PC_in,
    input  logic [31:0] Instruction,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic        two_src,
    output logic [31:0] PC_out,
    output logic [31:0] val1,
    output logic [31:0] val2,
    output logic [31:0] st_val,
    output logic [4:0]  dest,
    output logic [3:0]  exe_cmd,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        wb_en_out,
    output logic        is_imm,
    output logic [1:0]  br_type
);

    localparam logic [5:0] c_OP_ADD  = 6'd1;
    localparam logic [5:0] c_OP_SUB  = 6'd3;
    localparam logic [5:0] c_OP_AND  = 6'd5;
    localparam logic [5:0] c_OP_OR   = 6'd6;
    localparam logic [5:0] c_OP_NOR  = 6'd7;
    localparam logic [5:0] c_OP_XOR  = 6'd8;
    localparam logic [5:0] c_OP_SLA  = 6'd9;
    localparam logic [5:0] c_OP_SLL  = 6'd10;
    localparam logic [5:0] c_OP_SRA  = 6'd11;
    localparam logic [5:0] c_OP_SRL  = 6'd12;
    localparam logic [5:0] c_OP_ADDI = 6'd32;
    localparam logic [5:0] c_OP_SUBI = 6'd33;
    localparam logic [5:0] c_OP_LD   = 6'd36;
    localparam logic [5:0] c_OP_ST   = 6'd37;
    localparam logic [5:0] c_OP_BEZ  = 6'd40;
    localparam logic [5:0] c_OP_BNE  = 6'd41;
    localparam logic [5:0] c_OP_JMP  = 6'd42;

    localparam logic [1:0] c_BR_NONE = 2'b00;
    localparam logic [1:0] c_BR_BEZ  = 2'b01;
    localparam logic [1:0] c_BR_BNE  = 2'b10;
    localparam logic [1:0] c_BR_JMP  = 2'b11;

    logic [31:0] r_rf [32];

    logic [5:0]  w_opcode;
    logic [31:0] w_imm;
    logic        w_is_rtype;
    logic [3:0]  w_exe_cmd;
    logic        w_mem_r_en;
    logic        w_mem_w_en;
    logic        w_wb_en;
    logic        w_is_imm;
    logic [1:0]  w_br_type;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    assign w_opcode = Instruction[31:26];
    assign w_imm    = {{16{Instruction[15]}}, Instruction[15:0]};

    always_comb begin
        w_is_rtype = 1'b0;
        w_exe_cmd  = 4'b0000;
        w_mem_r_en = 1'b0;
        w_mem_w_en = 1'b0;
        w_wb_en    = 1'b0;
        w_is_imm   = 1'b0;
        w_br_type  = c_BR_NONE;
        case (w_opcode)
            c_OP_ADD: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b0001; w_wb_en = 1'b1; end
            c_OP_SUB: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b0010; w_wb_en = 1'b1; end
            c_OP_AND: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b0011; w_wb_en = 1'b1; end
            c_OP_OR:  begin w_is_rtype = 1'b1; w_exe_cmd = 4'b0100; w_wb_en = 1'b1; end
            c_OP_NOR: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b0101; w_wb_en = 1'b1; end
            c_OP_XOR: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b0110; w_wb_en = 1'b1; end
            c_OP_SLA,
            c_OP_SLL: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b0111; w_wb_en = 1'b1; end
            c_OP_SRA: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b1000; w_wb_en = 1'b1; end
            c_OP_SRL: begin w_is_rtype = 1'b1; w_exe_cmd = 4'b1001; w_wb_en = 1'b1; end
            c_OP_ADDI: begin w_exe_cmd = 4'b0001; w_is_imm = 1'b1; w_wb_en = 1'b1; end
            c_OP_SUBI: begin w_exe_cmd = 4'b0010; w_is_imm = 1'b1; w_wb_en = 1'b1; end
            c_OP_LD: begin
                w_exe_cmd  = 4'b0001;
                w_is_imm   = 1'b1;
                w_mem_r_en = 1'b1;
                w_wb_en    = 1'b1;
            end
            c_OP_ST: begin
                w_exe_cmd  = 4'b0001;
                w_is_imm   = 1'b1;
                w_mem_w_en = 1'b1;
            end
            c_OP_BEZ: begin w_br_type = c_BR_BEZ; w_is_imm = 1'b1; end
            c_OP_BNE: begin w_br_type = c_BR_BNE; w_is_imm = 1'b1; end
            c_OP_JMP: begin w_br_type = c_BR_JMP; w_is_imm = 1'b1; end
            default: ;
        endcase
    end

    // Non-R-type instructions carry their second register in the dest field
    // (ST data, BNE comparand).
    assign src1    = Instruction[20:16];
    assign src2    = w_is_rtype ? Instruction[15:11] : Instruction[25:21];
    assign two_src = w_is_rtype | (w_opcode == c_OP_ST) | (w_opcode == c_OP_BNE);

`ifdef ID_WB_BYPASS_EN
    always_comb begin
        w_rd1 = r_rf[src1];
        w_rd2 = r_rf[src2];
        if (wb_en && (wb_dest != 5'd0) && (wb_dest == src1)) w_rd1 = wb_value;
        if (wb_en && (wb_dest != 5'd0) && (wb_dest == src2)) w_rd2 = wb_value;
        if (src1 == 5'd0) w_rd1 = 32'd0;
        if (src2 == 5'd0) w_rd2 = 32'd0;
    end
`else
    assign w_rd1 = (src1 == 5'd0) ? 32'd0 : r_rf[src1];
    assign w_rd2 = (src2 == 5'd0) ? 32'd0 : r_rf[src2];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
        end else if (wb_en && (wb_dest != 5'd0)) begin
            r_rf[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || hazard) begin
            PC_out    <= 32'd0;
            val1      <= 32'd0;
            val2      <= 32'd0;
            st_val    <= 32'd0;
            dest      <= 5'd0;
            exe_cmd   <= 4'd0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            wb_en_out <= 1'b0;
            is_imm    <= 1'b0;
            br_type   <= c_BR_NONE;
        end else begin
            PC_out    <= PC_in;
            val1      <= w_rd1;
            val2      <= w_is_imm ? w_imm : w_rd2;
            st_val    <= w_rd2;
            dest      <= Instruction[25:21];
            exe_cmd   <= w_exe_cmd;
            mem_r_en  <= w_mem_r_en;
            mem_w_en  <= w_mem_w_en;
            wb_en_out <= w_wb_en;
            is_imm    <= w_is_imm;
            br_type   <= w_br_type;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module   : tb_id_stage
// Function : Directed self-checking bench for id_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic        hazard;
    logic        flush;
    logic [31:0] PC_in;
    logic [31:0] Instruction;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic        two_src;
    logic [31:0] PC_out;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val;
    logic [4:0]  dest;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en_out;
    logic        is_imm;
    logic [1:0]  br_type;

    int checks;
    int errors;

    id_stage dut (
        .clk(clk), .rst(rst), .hazard(hazard), .flush(flush),
        .PC_in(PC_in), .Instruction(Instruction),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .two_src(two_src),
        .PC_out(PC_out), .val1(val1), .val2(val2), .st_val(st_val),
        .dest(dest), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .wb_en_out(wb_en_out), .is_imm(is_imm),
        .br_type(br_type)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        wb_en = 1'b1; wb_dest = r; wb_value = v;
        Instruction = 32'd0;
        step();
        wb_en = 1'b0;
    endtask

    task automatic chk_ctrl(input string tag, input logic [3:0] e, input logic mr,
                            input logic mw, input logic w, input logic im, input logic [1:0] b);
        chk({tag, ".exe"},  32'(exe_cmd),   32'(e));
        chk({tag, ".mr"},   32'(mem_r_en),  32'(mr));
        chk({tag, ".mw"},   32'(mem_w_en),  32'(mw));
        chk({tag, ".wb"},   32'(wb_en_out), 32'(w));
        chk({tag, ".imm"},  32'(is_imm),    32'(im));
        chk({tag, ".br"},   32'(br_type),   32'(b));
    endtask

    initial begin
        checks = 0; errors = 0;
        clk_en = 1'b1;
        rst = 1'b1; hazard = 1'b0; flush = 1'b0;
        PC_in = 32'd0; Instruction = 32'd0;
        wb_en = 1'b0; wb_dest = 5'd0; wb_value = 32'd0;
        step(); step();
        // combinational source info valid even in reset
        Instruction = r_ins(6'd1, 5'd1, 5'd2, 5'd3);
        #1;
        chk("rst_src1", 32'(src1), 32'd2);
        chk("rst_src2", 32'(src2), 32'd3);
        chk("rst_val1", val1, 32'd0);
        rst = 1'b0;

        wb(5'd2, 32'd5);
        wb(5'd3, 32'd7);
        PC_in = 32'h0000_0100;
        Instruction = r_ins(6'd1, 5'd1, 5'd2, 5'd3);
        #1;
        chk("add_two_src", 32'(two_src), 32'd1);
        chk("add_src2", 32'(src2), 32'd3);
        step();
        chk("add_val1", val1, 32'd5);
        chk("add_val2", val2, 32'd7);
        chk("add_dest", 32'(dest), 32'd1);
        chk("add_pc", PC_out, 32'h0000_0100);
        chk_ctrl("add", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

        // asynchronous reset with the clock stopped
        clk_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_val1", val1, 32'd0);
        chk("arst_pc", PC_out, 32'd0);
        chk("arst_dest", 32'(dest), 32'd0);
        chk_ctrl("arst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        #2 rst = 1'b0;
        clk_en = 1'b1;
        step();
        chk("post_rst_val1", val1, 32'd0);
        chk("post_rst_val2", val2, 32'd0);
        chk("post_rst_exe", 32'(exe_cmd), 32'd1);
        chk("post_rst_wb", 32'(wb_en_out), 32'd1);

        wb(5'd2, 32'd5);
        wb(5'd3, 32'd7);

        Instruction = i_ins(6'd32, 5'd4, 5'd2, 16'hFFFD);
        #1;
        chk("addi_two_src", 32'(two_src), 32'd0);
        step();
        chk("addi_val1", val1, 32'd5);
        chk("addi_val2", val2, 32'hFFFF_FFFD);
        chk("addi_dest", 32'(dest), 32'd4);
        chk_ctrl("addi", 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);

        Instruction = i_ins(6'd37, 5'd2, 5'd3, 16'd4);
        #1;
        chk("st_two_src", 32'(two_src), 32'd1);
        chk("st_src2", 32'(src2), 32'd2);
        step();
        chk("st_stval", st_val, 32'd5);
        chk("st_val1", val1, 32'd7);
        chk("st_val2", val2, 32'd4);
        chk_ctrl("st", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);

        Instruction = r_ins(6'd3, 5'd9, 5'd3, 5'd2);
        step();
        chk("sub_exe", 32'(exe_cmd), 32'd2);
        chk("sub_val2", val2, 32'd5);

        Instruction = r_ins(6'd12, 5'd9, 5'd3, 5'd2);
        step();
        chk("srl_exe", 32'(exe_cmd), 32'd9);

        Instruction = i_ins(6'd36, 5'd6, 5'd2, 16'd8);
        hazard = 1'b1;
        step();
        chk_ctrl("ld_hz", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        hazard = 1'b0; flush = 1'b1;
        step();
        chk_ctrl("ld_fl", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("ld_fl_val1", val1, 32'd0);
        flush = 1'b0;
        step();
        chk_ctrl("ld", 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        chk("ld_val1", val1, 32'd5);
        chk("ld_val2", val2, 32'd8);
        chk("ld_dest", 32'(dest), 32'd6);

        // write-back must still commit under a flush
        wb_en = 1'b1; wb_dest = 5'd7; wb_value = 32'h77; flush = 1'b1;
        Instruction = r_ins(6'd1, 5'd1, 5'd2, 5'd3);
        step();
        wb_en = 1'b0; flush = 1'b0;
        chk("flwb_exe", 32'(exe_cmd), 32'd0);
        Instruction = r_ins(6'd1, 5'd8, 5'd7, 5'd0);
        step();
        chk("flwb_val1", val1, 32'h77);
        chk("flwb_val2", val2, 32'd0);

        wb(5'd0, 32'd9);
        Instruction = r_ins(6'd1, 5'd1, 5'd0, 5'd0);
        step();
        chk("r0_val1", val1, 32'd0);

        wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'h1234;
        Instruction = r_ins(6'd1, 5'd1, 5'd5, 5'd5);
        step();
        wb_en = 1'b0;
`ifdef ID_WB_BYPASS_EN
        chk("byp_val1", val1, 32'h1234);
        chk("byp_val2", val2, 32'h1234);
`else
        chk("byp_val1", val1, 32'd0);
        chk("byp_val2", val2, 32'd0);
`endif
        step();
        chk("byp_next_val1", val1, 32'h1234);

        Instruction = i_ins(6'd40, 5'd0, 5'd2, 16'd3);
        step();
        chk_ctrl("bez", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        Instruction = i_ins(6'd41, 5'd3, 5'd2, 16'h0010);
        #1;
        chk("bne_two_src", 32'(two_src), 32'd1);
        step();
        chk_ctrl("bne", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        chk("bne_stval", st_val, 32'd7);
        chk("bne_val2", val2, 32'h10);
        Instruction = i_ins(6'd42, 5'd0, 5'd0, 16'h0020);
        step();
        chk_ctrl("jmp", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);

        Instruction = r_ins(6'd63, 5'd3, 5'd2, 5'd3);
        #1;
        chk("op63_two_src", 32'(two_src), 32'd0);
        step();
        chk_ctrl("op63", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage pipelined processor, placed directly downstream of the instruction-fetch stage and its IF/ID latch. Decodes the 32-bit instruction into execute/memory/write-back controls, reads operands from an internal 32×32 register file, and accepts write-back from the WB stage. All results are captured in an internal ID/EX register, so the block presents the ID/EX pipeline boundary to the execute stage. Also exposes combinational source-register information to the hazard unit.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- hazard  in  1  hazard unit request: insert a bubble into ID/EX this cycle
- flush  in  1  branch taken in EX: squash the instruction currently in ID
- PC_in  in  32  PC+1 of the instruction in ID, from the IF/ID latch
- Instruction  in  32  instruction word, from the IF/ID latch
- wb_en  in  1  write-back enable from the WB stage
- wb_dest  in  5  write-back register index
- wb_value  in  32  write-back data
- src1  out  5  combinational, Instruction[20:16]
- src2  out  5  combinational; Instruction[15:11] for R-type, otherwise Instruction[25:21]
- two_src  out  1  combinational; high for R-type, ST and BNE
- PC_out  out  32  registered PC
- val1, val2, st_val  out  32 each  registered operands
- dest  out  5  registered, Instruction[25:21]
- exe_cmd  out  4  registered ALU command
- mem_r_en, mem_w_en, wb_en_out, is_imm  out  1 each  registered controls
- br_type  out  2  registered; 00 none, 01 BEZ, 10 BNE, 11 JMP

## Operation
- Fields: opcode [31:26], dest [25:21], src1 [20:16], src2 [15:11], imm [15:0]. imm is sign-extended to 32 bits.
- Decode by opcode:
  - 0 NOP: all controls 0.
  - 1 ADD: exe 0001. 3 SUB: 0010. 5 AND: 0011. 6 OR: 0100. 7 NOR: 0101. 8 XOR: 0110. 9 SLA and 10 SLL: 0111. 11 SRA: 1000. 12 SRL: 1001. All of these set wb_en_out.
  - 32 ADDI: exe 0001. 33 SUBI: exe 0010. Both set is_imm and wb_en_out.
  - 36 LD: exe 0001, is_imm, mem_r_en, wb_en_out.
  - 37 ST: exe 0001, is_imm, mem_w_en.
  - 40 BEZ: br 01, is_imm. 41 BNE: br 10, is_imm. 42 JMP: br 11, is_imm.
  - Any other opcode decodes as NOP.
- Operands:
  - val1 = rf[src1].
  - val2 = is_imm ? sext(imm) : rf[src2].
  - st_val = rf[src2].
  - BNE compares val1 with st_val in EX.
- Register file:
  - 32 entries × 32 bits, two combinational read ports, one write port.
  - A write occurs on the rising edge when wb_en=1 and wb_dest≠0.
  - R0 always reads 0; writes to R0 are ignored.
- ID/EX update on every rising edge, in priority order:
  - rst: clear all ID/EX outputs and the register file.
  - flush: load a bubble (all controls, exe_cmd, br_type and dest set to 0; PC_out and operands set to 0).
  - hazard: load a bubble, same as flush.
  - Otherwise: load the decoded instruction.
- The block has no freeze input. The IF stage and IF/ID latch hold the instruction during a hazard, and ID re-decodes it on the next cycle.

## Timing
- Reset: every registered output and every register file entry is 0 immediately on rst assertion, independent of clk.
- Latency: 1 cycle. An instruction present at edge N appears on the ID/EX outputs after edge N.
- src1, src2 and two_src are purely combinational from Instruction, with zero latency. They are valid during reset and during a bubble.
- Write-back and read in the same cycle: behaviour is set by the configuration macro (see Configuration).
- Simultaneous write-back and flush/hazard: the register file write still occurs; only the ID/EX load is replaced by a bubble.
- If rst asserts mid-stream, the in-flight instruction is lost; no write-back is committed at that edge.

## Configuration
- Macro: ID_WB_BYPASS_EN.
- Defined: when wb_en=1, wb_dest≠0 and wb_dest matches a read address, that read port returns wb_value in the same cycle (write-first). This forwarding applies to val1, val2 and st_val.
- Undefined: reads return the stored value, and the written value becomes visible from the next cycle. The hazard unit must then cover one extra cycle of WB distance.

## Test plan
- Reset: assert rst mid-cycle with clk idle. All outputs read 0 at once. After release, ADD R1,R2,R3 (R2=R3=0) gives val1=0, val2=0, exe_cmd=0001, wb_en_out=1.
- Write-back then decode: write R2=5 and R3=7 via WB. Decode ADD R1,R2,R3: val1=5, val2=7, dest=1, two_src=1, src2=3.
- Immediate: ADDI R4,R2,-3 (imm 0xFFFD) gives val2=0xFFFFFFFD, is_imm=1, two_src=0. ST R2,R3,4 gives st_val=rf[2], mem_w_en=1, two_src=1.
- Bubble and flush: decode LD with hazard=1, then the same LD with flush=1. Both cycles show exe_cmd=0, mem_r_en=0, wb_en_out=0. On the cycle with both low, mem_r_en=1.
- R0 and bypass: WB of R0=9 leaves R0 reading 0. Same-cycle WB of R5=0x1234 while decoding an instruction reading R5 gives val1=0x1234 with ID_WB_BYPASS_EN defined, and the old value without it.
- Undefined opcode 63: all controls 0 and br_type=00.
